// File: rtl/id_ex_pipe.sv
// ---------------------------------------------------------------------------
// id_ex_pipe
//
// Pipeline register between decode/register-read and execute. Incoming
// bundles are handed over with a valid/ready handshake. A two-entry store
// (main entry plus one skid entry) absorbs a single cycle of back-pressure,
// so in_ready comes straight from a register and never from out_ready.
// A synchronous flush discards every held entry. A saturating counter tracks
// the cycles in which execute was ready but no entry was presented.
//
// Ports:
//   clock, reset_n               rising-edge clock, async active-low reset
//   flush                        drop all held entries and this cycle's input
//   in_valid / in_ready          decode-side handshake
//   read1, read2, sign_extended  operands and immediate from decode
//   instruction, pc              instruction word and its PC
//   aluOp .. memtoReg            EX / MEM / WB control from decode
//   out_valid / out_ready        execute-side handshake
//   Read1, Read2, Sign_extended, Pc       registered data of the main entry
//   alu_ctrl_data, write_reg, rn_reg, rm_reg  decoded instruction fields
//   AluOp .. MemtoReg            registered control, zero while out_valid=0
//   bubble_count                 saturating count of ready-but-empty cycles
// ---------------------------------------------------------------------------
module id_ex_pipe #(
    parameter int DATA_W = 64,
    parameter int IMM_W  = 64,
    parameter int PC_W   = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] read1,
    input  logic [DATA_W-1:0] read2,
    input  logic [IMM_W-1:0]  sign_extended,
    input  logic [31:0]       instruction,
    input  logic [PC_W-1:0]   pc,
    input  logic [1:0]        aluOp,
    input  logic              aluSrc,
    input  logic              branch,
    input  logic              uncond_branch,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              regWrite,
    input  logic              memtoReg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Read1,
    output logic [DATA_W-1:0] Read2,
    output logic [IMM_W-1:0]  Sign_extended,
    output logic [PC_W-1:0]   Pc,
    output logic [10:0]       alu_ctrl_data,
    output logic [REG_W-1:0]  write_reg,
    output logic [REG_W-1:0]  rn_reg,
    output logic [REG_W-1:0]  rm_reg,
    output logic [1:0]        AluOp,
    output logic              ALUSrc,
    output logic              Branch,
    output logic              Uncond_Branch,
    output logic              Memread,
    output logic              Memwrite,
    output logic              RegWrite,
    output logic              MemtoReg,
    output logic [CNT_W-1:0]  bubble_count
);

    // One held bundle: data, decoded fields and control travel together.
    typedef struct packed {
        logic [DATA_W-1:0] read1;
        logic [DATA_W-1:0] read2;
        logic [IMM_W-1:0]  imm;
        logic [PC_W-1:0]   pc;
        logic [10:0]       aluCtrl;
        logic [REG_W-1:0]  writeReg;
        logic [REG_W-1:0]  rnReg;
        logic [REG_W-1:0]  rmReg;
        logic [1:0]        aluOp;
        logic              aluSrc;
        logic              branch;
        logic              uncondBranch;
        logic              memRead;
        logic              memWrite;
        logic              regWrite;
        logic              memToReg;
    } entry_t;

    entry_t            inEntry;
    entry_t            main_q, main_d;
    entry_t            skid_q, skid_d;
    logic              mainValid_q, mainValid_d;
    logic              skidValid_q, skidValid_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;
    logic              accept;
    logic              drain;

    // Decode the instruction word as it arrives so that both the main and
    // the skid entry already carry the split-out register and ALU fields.
    always_comb begin
        inEntry              = '0;
        inEntry.read1        = read1;
        inEntry.read2        = read2;
        inEntry.imm          = sign_extended;
        inEntry.pc           = pc;
        inEntry.aluCtrl      = instruction[31:21];
        inEntry.writeReg     = instruction[REG_W-1:0];
        inEntry.rnReg        = instruction[5+REG_W-1:5];
        inEntry.rmReg        = instruction[16+REG_W-1:16];
        inEntry.aluOp        = aluOp;
        inEntry.aluSrc       = aluSrc;
        inEntry.branch       = branch;
        inEntry.uncondBranch = uncond_branch;
        inEntry.memRead      = memread;
        inEntry.memWrite     = memwrite;
        inEntry.regWrite     = regWrite;
        inEntry.memToReg     = memtoReg;
    end

    // The skid entry is the only thing that can make us refuse input, so
    // ready is simply "skid empty" and depends on registered state only.
    assign in_ready = ~skidValid_q;
    assign accept   = in_valid & ~skidValid_q;
    assign drain    = mainValid_q & out_ready;

    // Next-state for the two entries. When the main slot frees up (empty or
    // being consumed) the skid entry has priority, which keeps FIFO order;
    // otherwise a new bundle goes straight into main. When main is stalled a
    // new bundle parks in skid. A flush only clears the valid flags, so the
    // data outputs keep showing the last bundle held in main.
    always_comb begin
        main_d      = main_q;
        skid_d      = skid_q;
        mainValid_d = mainValid_q;
        skidValid_d = skidValid_q;
        if (flush) begin
            mainValid_d = 1'b0;
            skidValid_d = 1'b0;
        end else if (!mainValid_q || drain) begin
            if (skidValid_q) begin
                main_d      = skid_q;
                mainValid_d = 1'b1;
                skidValid_d = 1'b0;
            end else if (accept) begin
                main_d      = inEntry;
                mainValid_d = 1'b1;
            end else begin
                mainValid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d      = inEntry;
            skidValid_d = 1'b1;
        end
    end

    // Count cycles where execute could have taken an entry but none was
    // held. The counter sticks at all-ones rather than wrapping, and keeps
    // counting through a flush.
    always_comb begin
        bubble_d = bubble_q;
        if (out_ready && !mainValid_q && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    // State registers; reset clears everything immediately, data included.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_q      <= '0;
            skid_q      <= '0;
            mainValid_q <= 1'b0;
            skidValid_q <= 1'b0;
            bubble_q    <= '0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            mainValid_q <= mainValid_d;
            skidValid_q <= skidValid_d;
            bubble_q    <= bubble_d;
        end
    end

    // Data and decoded fields always show the main entry; control is masked
    // by the valid flag so an empty stage looks like a NOP downstream.
    assign out_valid     = mainValid_q;
    assign Read1         = main_q.read1;
    assign Read2         = main_q.read2;
    assign Sign_extended = main_q.imm;
    assign Pc            = main_q.pc;
    assign alu_ctrl_data = main_q.aluCtrl;
    assign write_reg     = main_q.writeReg;
    assign rn_reg        = main_q.rnReg;
    assign rm_reg        = main_q.rmReg;
    assign AluOp         = main_q.aluOp & {2{mainValid_q}};
    assign ALUSrc        = main_q.aluSrc & mainValid_q;
    assign Branch        = main_q.branch & mainValid_q;
    assign Uncond_Branch = main_q.uncondBranch & mainValid_q;
    assign Memread       = main_q.memRead & mainValid_q;
    assign Memwrite      = main_q.memWrite & mainValid_q;
    assign RegWrite      = main_q.regWrite & mainValid_q;
    assign MemtoReg      = main_q.memToReg & mainValid_q;
    assign bubble_count  = bubble_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe
//
// Self-checking bench for id_ex_pipe. The reference model treats the stage
// as a FIFO of at most two bundles: the head is what execute sees, input is
// taken while fewer than two are held, flush empties it. The counter is
// instantiated narrow (CNT_W=2) so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe;

    localparam int DW = 64;
    localparam int IW = 64;
    localparam int PW = 64;
    localparam int RW = 5;
    localparam int CW = 2;
    localparam int DV = 2*DW + IW + PW + 11 + 3*RW;
    localparam int BUB_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
        logic [IW-1:0] imm;
        logic [PW-1:0] pc;
        logic [31:0]   instr;
        logic [8:0]    ctrl;   // {aluOp[1:0], aluSrc, branch, uncond, memread, memwrite, regWrite, memtoReg}
    } bundle_t;

    logic clock;
    logic reset_n;
    logic flush;
    logic in_valid;
    logic out_ready;
    bundle_t inB;

    logic              in_ready, out_valid;
    logic [DW-1:0]     Read1, Read2;
    logic [IW-1:0]     Sign_extended;
    logic [PW-1:0]     Pc;
    logic [10:0]       alu_ctrl_data;
    logic [RW-1:0]     write_reg, rn_reg, rm_reg;
    logic [1:0]        AluOp;
    logic              ALUSrc, Branch, Uncond_Branch, Memread, Memwrite, RegWrite, MemtoReg;
    logic [CW-1:0]     bubble_count;

    // Reference model state
    bundle_t     q[$];
    bundle_t     shown;
    int unsigned bub;

    int total;
    int bad;

    id_ex_pipe #(
        .DATA_W(DW), .IMM_W(IW), .PC_W(PW), .REG_W(RW), .CNT_W(CW)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .read1(inB.r1),
        .read2(inB.r2),
        .sign_extended(inB.imm),
        .instruction(inB.instr),
        .pc(inB.pc),
        .aluOp(inB.ctrl[8:7]),
        .aluSrc(inB.ctrl[6]),
        .branch(inB.ctrl[5]),
        .uncond_branch(inB.ctrl[4]),
        .memread(inB.ctrl[3]),
        .memwrite(inB.ctrl[2]),
        .regWrite(inB.ctrl[1]),
        .memtoReg(inB.ctrl[0]),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Read1(Read1),
        .Read2(Read2),
        .Sign_extended(Sign_extended),
        .Pc(Pc),
        .alu_ctrl_data(alu_ctrl_data),
        .write_reg(write_reg),
        .rn_reg(rn_reg),
        .rm_reg(rm_reg),
        .AluOp(AluOp),
        .ALUSrc(ALUSrc),
        .Branch(Branch),
        .Uncond_Branch(Uncond_Branch),
        .Memread(Memread),
        .Memwrite(Memwrite),
        .RegWrite(RegWrite),
        .MemtoReg(MemtoReg),
        .bubble_count(bubble_count)
    );

    // Free-running clock, period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed output groups, flattened for compact comparison.
    function automatic logic [DV-1:0] actData();
        return {Read1, Read2, Sign_extended, Pc, alu_ctrl_data, write_reg, rn_reg, rm_reg};
    endfunction

    function automatic logic [8:0] actCtrl();
        return {AluOp, ALUSrc, Branch, Uncond_Branch, Memread, Memwrite, RegWrite, MemtoReg};
    endfunction

    // Expected output groups derived from the FIFO model.
    function automatic logic [DV-1:0] expData();
        return {shown.r1, shown.r2, shown.imm, shown.pc, shown.instr[31:21],
                shown.instr[RW-1:0], shown.instr[5+RW-1:5], shown.instr[16+RW-1:16]};
    endfunction

    function automatic logic [8:0] expCtrl();
        return (q.size() > 0) ? shown.ctrl : 9'd0;
    endfunction

    function automatic bundle_t randBundle();
        bundle_t b;
        b.r1    = {$urandom, $urandom};
        b.r2    = {$urandom, $urandom};
        b.imm   = {$urandom, $urandom};
        b.pc    = {$urandom, $urandom};
        b.instr = $urandom;
        b.ctrl  = 9'($urandom);
        return b;
    endfunction

    function automatic bundle_t pcBundle(input logic [PW-1:0] p);
        bundle_t b;
        b    = randBundle();
        b.pc = p;
        return b;
    endfunction

    function automatic void modelReset();
        q.delete();
        shown = '0;
        bub   = 0;
    endfunction

    // Drive one cycle of inputs, let the edge happen, advance the model with
    // the values that were present at that edge, then settle 1 time unit.
    task automatic applyStimulus(input logic iv, input bundle_t b, input logic ordy, input logic fl);
        int  held;
        bit  acc;
        bit  dr;
        in_valid  = iv;
        inB       = b;
        out_ready = ordy;
        flush     = fl;
        @(posedge clock);
        held = q.size();
        acc  = iv && (held < 2);
        dr   = (held > 0) && ordy;
        if (ordy && held == 0 && bub < BUB_MAX) bub++;
        if (fl) begin
            q.delete();
        end else begin
            if (dr) void'(q.pop_front());
            if (acc) q.push_back(b);
        end
        if (q.size() > 0) shown = q[0];
        #1;
    endtask

    task automatic applyReset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        inB       = '0;
        modelReset();
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        applyReset();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_handshake: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
        total++;
        if (actData() !== '0 || actCtrl() !== 9'd0 || bubble_count !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got data=%h ctrl=%h bub=%0d want all zero", actData(), actCtrl(), bubble_count);
        end
    endtask

    task automatic test_decode();
        bundle_t b;
        applyReset();
        b       = '0;
        b.instr = 32'h8B02_0020;
        b.r1    = 64'd5;
        b.r2    = 64'd7;
        b.ctrl  = 9'b0_0000_0010;
        applyStimulus(1'b1, b, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b1 || alu_ctrl_data !== 11'h458 || write_reg !== 5'd0 ||
            rn_reg !== 5'd1 || rm_reg !== 5'd2) begin
            bad++;
            $display("[TB] FAIL decode_fields: got v=%b alu=%h wr=%0d rn=%0d rm=%0d want v=1 alu=458 wr=0 rn=1 rm=2",
                     out_valid, alu_ctrl_data, write_reg, rn_reg, rm_reg);
        end
        total++;
        if (Read1 !== 64'd5 || Read2 !== 64'd7 || RegWrite !== 1'b1 || Memwrite !== 1'b0) begin
            bad++;
            $display("[TB] FAIL decode_data: got r1=%0d r2=%0d regWrite=%b memwrite=%b want 5 7 1 0",
                     Read1, Read2, RegWrite, Memwrite);
        end
    endtask

    task automatic test_stream();
        applyReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, pcBundle(PW'(i * 4)), 1'b1, 1'b0);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || Pc !== PW'(i * 4)) begin
                bad++;
                $display("[TB] FAIL stream_%0d: got v=%b rdy=%b pc=%0d want v=1 rdy=1 pc=%0d",
                         i, out_valid, in_ready, Pc, i * 4);
            end
            total++;
            if (actData() !== expData() || actCtrl() !== expCtrl()) begin
                bad++;
                $display("[TB] FAIL stream_payload_%0d: got %h/%h want %h/%h", i, actData(), actCtrl(), expData(), expCtrl());
            end
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b0 || actCtrl() !== 9'd0 || Pc !== PW'(12)) begin
            bad++;
            $display("[TB] FAIL stream_drained: got v=%b ctrl=%h pc=%0d want v=0 ctrl=0 pc=12", out_valid, actCtrl(), Pc);
        end
    endtask

    task automatic test_back_pressure();
        applyReset();
        applyStimulus(1'b1, pcBundle(PW'(0)), 1'b1, 1'b0);
        applyStimulus(1'b1, pcBundle(PW'(4)), 1'b0, 1'b0);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || Pc !== PW'(0)) begin
            bad++;
            $display("[TB] FAIL bp_skid_full: got rdy=%b v=%b pc=%0d want rdy=0 v=1 pc=0", in_ready, out_valid, Pc);
        end
        // Full and stalled: an offered bundle must be refused and nothing moves.
        applyStimulus(1'b1, pcBundle(PW'(8)), 1'b0, 1'b0);
        total++;
        if (in_ready !== 1'b0 || Pc !== PW'(0) || actData() !== expData()) begin
            bad++;
            $display("[TB] FAIL bp_hold: got rdy=%b pc=%0d want rdy=0 pc=0", in_ready, Pc);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b1 || Pc !== PW'(4) || in_ready !== 1'b1 || actCtrl() !== expCtrl()) begin
            bad++;
            $display("[TB] FAIL bp_second: got v=%b pc=%0d rdy=%b want v=1 pc=4 rdy=1", out_valid, Pc, in_ready);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_empty: got v=%b want v=0 (pc=8 must not appear)", out_valid);
        end
    endtask

    task automatic test_flush();
        bundle_t b;
        applyReset();
        applyStimulus(1'b1, pcBundle(PW'(100)), 1'b0, 1'b0);
        applyStimulus(1'b1, pcBundle(PW'(104)), 1'b0, 1'b0);
        b = pcBundle(PW'(108));
        b.ctrl[2] = 1'b1;
        applyStimulus(1'b1, b, 1'b0, 1'b1);
        total++;
        if (out_valid !== 1'b0 || Memwrite !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL flush_clear: got v=%b memwrite=%b rdy=%b want 0 0 1", out_valid, Memwrite, in_ready);
        end
        total++;
        if (Pc !== PW'(100) || actData() !== expData()) begin
            bad++;
            $display("[TB] FAIL flush_data_hold: got pc=%0d want pc=100", Pc);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b0 || Pc !== PW'(100)) begin
            bad++;
            $display("[TB] FAIL flush_no_ghost: got v=%b pc=%0d want v=0 pc=100", out_valid, Pc);
        end
    endtask

    task automatic test_bubble_saturate();
        int want[4] = '{1, 2, 3, 3};
        applyReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            total++;
            if (bubble_count !== CW'(want[i])) begin
                bad++;
                $display("[TB] FAIL bubble_%0d: got %0d want %0d", i, bubble_count, want[i]);
            end
        end
        // Stalled or busy cycles must not count.
        applyStimulus(1'b1, pcBundle(PW'(0)), 1'b0, 1'b0);
        applyReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        total++;
        if (bubble_count !== CW'(0)) begin
            bad++;
            $display("[TB] FAIL bubble_not_ready: got %0d want 0", bubble_count);
        end
    endtask

    task automatic test_async_reset();
        bundle_t b;
        applyReset();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        b = pcBundle(PW'(40));
        b.ctrl = 9'h1FF;
        applyStimulus(1'b1, b, 1'b0, 1'b0);
        applyStimulus(1'b1, pcBundle(PW'(44)), 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || actCtrl() !== 9'h1FF || bubble_count !== CW'(1)) begin
            bad++;
            $display("[TB] FAIL areset_pre: got v=%b ctrl=%h bub=%0d want 1 1ff 1", out_valid, actCtrl(), bubble_count);
        end
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || actCtrl() !== 9'd0 || bubble_count !== '0 ||
            in_ready !== 1'b1 || actData() !== '0) begin
            bad++;
            $display("[TB] FAIL areset_immediate: got v=%b ctrl=%h bub=%0d rdy=%b want 0 0 0 1",
                     out_valid, actCtrl(), bubble_count, in_ready);
        end
        modelReset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b0 || bubble_count !== CW'(1)) begin
            bad++;
            $display("[TB] FAIL areset_after: got v=%b bub=%0d want 0 1", out_valid, bubble_count);
        end
    endtask

    task automatic test_random();
        logic iv, ordy, fl;
        applyReset();
        for (int i = 0; i < 400; i++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 24) == 0);
            applyStimulus(iv, randBundle(), ordy, fl);
            total++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                bad++;
                $display("[TB] FAIL rand_handshake_%0d: got v=%b rdy=%b want v=%b rdy=%b",
                         i, out_valid, in_ready, q.size() > 0, q.size() < 2);
            end
            total++;
            if (actData() !== expData()) begin
                bad++;
                $display("[TB] FAIL rand_data_%0d: got %h want %h", i, actData(), expData());
            end
            total++;
            if (actCtrl() !== expCtrl()) begin
                bad++;
                $display("[TB] FAIL rand_ctrl_%0d: got %h want %h", i, actCtrl(), expCtrl());
            end
            total++;
            if (bubble_count !== CW'(bub)) begin
                bad++;
                $display("[TB] FAIL rand_bubble_%0d: got %0d want %0d", i, bubble_count, bub);
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_decode();
        test_stream();
        test_back_pressure();
        test_flush();
        test_bubble_saturate();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
